// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared definitions for the iterative divider.
//   - operation encodings (RV32M DIV/DIVU/REM/REMU funct3 low bits)
//   - FSM state encoding
//   - op decode helpers
package div_iter_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Signed ops have op[0] clear.
  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Remainder ops have op[1] set.
  function automatic logic is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/stdffr.sv
// stdffr: plain D flop bank with asynchronous active-low reset to zero.
//   clk   : clock
//   arstn : asynchronous reset, active-low
//   d     : next value
//   q     : registered value
module stdffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/stdffre.sv
// stdffre: D flop bank with load enable and asynchronous active-low reset
// to zero.
//   clk   : clock
//   arstn : asynchronous reset, active-low
//   en    : load enable; q holds when low
//   d     : next value
//   q     : registered value
module stdffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One request in over req_valid/req_ready, one result out over
// resp_valid/resp_ready. Divide-by-zero and signed overflow finish one
// cycle after accept; all other operations take W iterations.
//   clk, arstn          : clock, asynchronous active-low reset
//   flush               : abandon any operation in progress, drop result
//   req_valid/req_ready : request handshake
//   req_op              : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b        : dividend, divisor
//   resp_valid/ready    : response handshake
//   resp_data           : quotient or remainder (qualify with resp_valid)
//   busy                : high whenever not IDLE
module div_iter
  import div_iter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;

  div_state_t state_reg, state_next;

  logic [1:0]   op_reg;
  logic         neg_quo_reg, neg_rem_reg;
  logic [W-1:0] resp_data_reg;

  logic [W-1:0]  rem_reg, quo_reg, dvs_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  rem_d, quo_d;
  logic [CW-1:0] cnt_d;

  logic          accept;
  logic          calc_step;
  logic          last_iter;
  logic          b_zero, ovf, special;
  logic [W-1:0]  a_abs, b_abs;
  logic [W-1:0]  special_data;
  logic [W:0]    rem_shift, trial;
  logic [W-1:0]  rem_step, quo_step;
  logic [W-1:0]  fix_quo, fix_rem, final_data;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign req_ready = (state_reg == ST_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  assign a_abs = (is_signed(req_op) && req_a[W-1]) ? -req_a : req_a;
  assign b_abs = (is_signed(req_op) && req_b[W-1]) ? -req_b : req_b;

  assign b_zero  = (req_b == '0);
  assign ovf     = is_signed(req_op) && (req_a == {1'b1, {(W-1){1'b0}}}) && (&req_b);
  assign special = b_zero | ovf;

  // On overflow the quotient is the dividend itself (most negative value).
  always_comb begin
    special_data = '0;
    if (is_rem(req_op)) special_data = b_zero ? req_a : '0;
    else                special_data = b_zero ? '1    : req_a;
  end

  // ---------------------------------------------------------------------
  // Iteration step. The dividend is loaded into the quotient register and
  // shifted out of its MSB into the remainder while quotient bits enter at
  // the LSB. The remainder is always below the divisor, so W bits hold it;
  // only the shifted trial value needs the extra bit.
  // ---------------------------------------------------------------------
  assign rem_shift = {rem_reg, quo_reg[W-1]};
  assign trial     = rem_shift - {1'b0, dvs_reg};
  assign rem_step  = trial[W] ? rem_shift[W-1:0] : trial[W-1:0];
  assign quo_step  = {quo_reg[W-2:0], ~trial[W]};
  assign last_iter = (cnt_reg == CW'(W - 1));

  assign fix_quo    = neg_quo_reg ? -quo_step : quo_step;
  assign fix_rem    = neg_rem_reg ? -rem_step : rem_step;
  assign final_data = is_rem(op_reg) ? fix_rem : fix_quo;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  assign calc_step = (state_reg == ST_CALC) & ~flush;

  assign rem_d = accept ? '0    : rem_step;
  assign quo_d = accept ? a_abs : quo_step;
  assign cnt_d = accept ? '0    : cnt_reg + 1'b1;

  stdffre #(.W(W)) u_rem (
    .clk(clk), .arstn(arstn), .en(accept | calc_step), .d(rem_d), .q(rem_reg)
  );

  stdffre #(.W(W)) u_quo (
    .clk(clk), .arstn(arstn), .en(accept | calc_step), .d(quo_d), .q(quo_reg)
  );

  stdffre #(.W(W)) u_dvs (
    .clk(clk), .arstn(arstn), .en(accept), .d(b_abs), .q(dvs_reg)
  );

  stdffre #(.W(CW)) u_cnt (
    .clk(clk), .arstn(arstn), .en(accept | calc_step), .d(cnt_d), .q(cnt_reg)
  );

  // Op and sign-fixup flags are captured at accept; the response is written
  // exactly once, when the FSM enters DONE.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      op_reg        <= '0;
      neg_quo_reg   <= 1'b0;
      neg_rem_reg   <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      if (accept) begin
        op_reg      <= req_op;
        neg_quo_reg <= (req_op == DIV_OP_DIV) & (req_a[W-1] ^ req_b[W-1]);
        neg_rem_reg <= (req_op == DIV_OP_REM) & req_a[W-1];
        if (special) resp_data_reg <= special_data;
      end
      if (calc_step && last_iter) resp_data_reg <= final_data;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_next = ST_DONE;
      ST_DONE: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Flush wins over every transition, including a DONE-cycle handshake.
    if (flush) state_next = ST_IDLE;
  end

  assign resp_valid = (state_reg == ST_DONE);
  assign resp_data  = resp_data_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        arstn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter #(.W(32)) dut (
    .clk(clk), .arstn(arstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency check on the first cycle of resp_valid, data check on
  // each completed transfer.
  always @(negedge clk) begin
    if (arstn) begin
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got resp_valid=1 data=0x%08h expected no response (cycle %0d)",
                   resp_data, cyc);
        end else begin
          chk("resp_latency", cyc, sb[0].due);
        end
      end
      if (resp_valid && resp_ready && !flush && sb.size() != 0) begin
        chk("resp_data", resp_data, sb[0].data);
        $display("resp cycle=%0d data=0x%08h expected=0x%08h", cyc, resp_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
    prev_valid = resp_valid;
  end

  // Drive one request; expected value pushed at the accept cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout: got req_ready=0 expected 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    if (push) sb.push_back('{exp, cyc + lat});
    $display("req cycle=%0d op=%0d a=0x%08h b=0x%08h expect=0x%08h", cyc, op, a, b, exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!resp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL valid_timeout: got resp_valid=0 expected 1");
    end
  endtask

  initial begin
    arstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    arstn = 1'b1;
    @(posedge clk); #1;

    // Unsigned normal path
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1); drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1); drain();
    issue(OP_REMU, 32'hFFFFFFFF, 32'h10, 32'hF, 33, 1); drain();
    issue(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 1); drain();

    // Signed sign fixups
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1); drain();
    issue(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1); drain();
    issue(OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 1); drain();
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1); drain();

    // Divide by zero and overflow (one-cycle results)
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1); drain();
    issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1); drain();
    issue(OP_DIVU, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 1); drain();
    issue(OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 1); drain();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1); drain();
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1); drain();

    // Backpressure in DONE
    resp_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data", resp_data, 32'd14);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_valid", 32'(resp_valid), 32'd0);
    chk("bp_after_req_ready", 32'(req_ready), 32'd1);
    drain();

    // Flush in DONE together with resp_ready: result dropped
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1);
    @(negedge clk);
    chk("fd_valid_before", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    chk("fd_valid_after", 32'(resp_valid), 32'd0);
    chk("fd_busy_after", 32'(busy), 32'd0);

    // Flush with a request in IDLE: no accept
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd9; req_b = 32'd3;
    @(negedge clk);
    chk("fi_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("fi_busy", 32'(busy), 32'd0);

    // Flush on CALC cycle 10
    @(posedge clk); #1;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fc_busy", 32'(busy), 32'd0);
    chk("fc_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1); drain();

    // Asynchronous reset mid-CALC
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    repeat (5) @(posedge clk);
    #1;
    arstn = 1'b0;
    #1;
    chk("ar_req_ready", 32'(req_ready), 32'd1);
    chk("ar_resp_valid", 32'(resp_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_resp_data", resp_data, 32'd0);
    #1;
    arstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ar_idle_after", 32'(busy), 32'd0);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1); drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
